// File: rtl/conv_out_streamer.sv
// Streams a finished convolution result frame out of the result buffer in raster order.
// The buffer has one cycle of read latency. A 2-entry skid FIFO decouples it from downstream backpressure.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | waiting for start; read address parked at (0,0)
//   RUN   | issuing buffer reads whenever the FIFO has credit
//   DRAIN | all reads issued; waiting for the m_eof beat to be accepted
//   FIN   | one-cycle finish pulse, then back to IDLE
module conv_out_streamer #(
   parameter  int SIZE      = 256,
   parameter  int SIZEKer   = 3,
   parameter  int WIDTH_BIT = 16,
   localparam int OUT       = SIZE - SIZEKer + 1,
   localparam int AW        = (OUT > 1) ? $clog2(OUT) : 1
) (
   input  logic                        clock,
   input  logic                        nreset,
   input  logic                        start,
   output logic                        rd_en,
   output logic [AW-1:0]               rd_row,
   output logic [AW-1:0]               rd_col,
   input  logic signed [WIDTH_BIT-1:0] rd_data,
   output logic                        m_valid,
   input  logic                        m_ready,
   output logic signed [WIDTH_BIT-1:0] m_data,
   output logic                        m_eol,
   output logic                        m_eof,
   output logic                        busy,
   output logic                        finish
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

   localparam logic [AW-1:0] LAST = AW'(OUT - 1);

   state_t                      state_q, state_d;
   logic [1:0]                  cnt_q;
   logic                        fly_q, fly_eol_q, fly_eof_q;
   logic signed [WIDTH_BIT-1:0] tail_data_q;
   logic                        tail_eol_q, tail_eof_q;
   logic                        rd_issue, pop, push, credit, at_eol, at_eof;

   assign at_eol  = (rd_col == LAST);
   assign at_eof  = at_eol && (rd_row == LAST);
   assign m_valid = (cnt_q != 2'd0);
   assign pop     = m_valid && m_ready;
   assign push    = fly_q;
   // A beat leaving this cycle frees its slot in time for the read issued now.
   assign credit  = ({1'b0, cnt_q} + {2'b00, fly_q}) < (3'd2 + {2'b00, pop});
   assign rd_en   = rd_issue & nreset;

   always_ff @(posedge clock or negedge nreset) begin
      if (!nreset) state_q <= IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d  = state_q;
      rd_issue = 1'b0;
      busy     = 1'b0;
      finish   = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               rd_issue = 1'b1;
               state_d  = at_eof ? DRAIN : RUN;
            end
         end
         RUN: begin
            busy = 1'b1;
            if (credit) begin
               rd_issue = 1'b1;
               if (at_eof) state_d = DRAIN;
            end
         end
         DRAIN: begin
            busy = 1'b1;
            if (pop && m_eof) state_d = FIN;
         end
         FIN: begin
            finish  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Wrapping after the last pixel leaves the address at (0,0) for the next frame.
   always_ff @(posedge clock or negedge nreset) begin
      if (!nreset) begin
         rd_row <= '0;
         rd_col <= '0;
      end else if (rd_issue) begin
         if (at_eol) begin
            rd_col <= '0;
            rd_row <= at_eof ? '0 : rd_row + AW'(1);
         end else begin
            rd_col <= rd_col + AW'(1);
         end
      end
   end

   always_ff @(posedge clock or negedge nreset) begin
      if (!nreset) begin
         fly_q     <= 1'b0;
         fly_eol_q <= 1'b0;
         fly_eof_q <= 1'b0;
      end else begin
         fly_q     <= rd_en;
         fly_eol_q <= at_eol;
         fly_eof_q <= at_eof;
      end
   end

   // Head entry drives the stream outputs directly; it only changes on a pop or an empty-FIFO push.
   always_ff @(posedge clock or negedge nreset) begin
      if (!nreset) begin
         cnt_q       <= 2'd0;
         m_data      <= '0;
         m_eol       <= 1'b0;
         m_eof       <= 1'b0;
         tail_data_q <= '0;
         tail_eol_q  <= 1'b0;
         tail_eof_q  <= 1'b0;
      end else begin
         case ({push, pop})
            2'b10: begin
               if (cnt_q == 2'd0) begin
                  m_data <= rd_data;
                  m_eol  <= fly_eol_q;
                  m_eof  <= fly_eof_q;
               end else begin
                  tail_data_q <= rd_data;
                  tail_eol_q  <= fly_eol_q;
                  tail_eof_q  <= fly_eof_q;
               end
               cnt_q <= cnt_q + 2'd1;
            end
            2'b01: begin
               if (cnt_q == 2'd2) begin
                  m_data <= tail_data_q;
                  m_eol  <= tail_eol_q;
                  m_eof  <= tail_eof_q;
               end
               cnt_q <= cnt_q - 2'd1;
            end
            2'b11: begin
               if (cnt_q == 2'd2) begin
                  m_data      <= tail_data_q;
                  m_eol       <= tail_eol_q;
                  m_eof       <= tail_eof_q;
                  tail_data_q <= rd_data;
                  tail_eol_q  <= fly_eol_q;
                  tail_eof_q  <= fly_eof_q;
               end else begin
                  m_data <= rd_data;
                  m_eol  <= fly_eol_q;
                  m_eof  <= fly_eof_q;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_conv_out_streamer.sv
// Bench for conv_out_streamer: a 3x3-output instance for the main frame tests, and a 1x1-output instance for
// the single-pixel case.
module tb_conv_out_streamer;

   localparam int W     = 16;
   localparam int OUT_A = 3;
   localparam int NPIX  = OUT_A * OUT_A;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic nreset;

   logic                a_start, a_rd_en, a_m_valid, a_m_ready, a_m_eol, a_m_eof, a_busy, a_finish;
   logic [1:0]          a_rd_row, a_rd_col;
   logic signed [W-1:0] a_rd_data, a_m_data;

   logic                b_start, b_rd_en, b_m_valid, b_m_ready, b_m_eol, b_m_eof, b_busy, b_finish;
   logic [0:0]          b_rd_row, b_rd_col;
   logic signed [W-1:0] b_rd_data, b_m_data;

   conv_out_streamer #(.SIZE(5), .SIZEKer(3), .WIDTH_BIT(W)) u_a (
      .clock(clock), .nreset(nreset), .start(a_start),
      .rd_en(a_rd_en), .rd_row(a_rd_row), .rd_col(a_rd_col), .rd_data(a_rd_data),
      .m_valid(a_m_valid), .m_ready(a_m_ready), .m_data(a_m_data),
      .m_eol(a_m_eol), .m_eof(a_m_eof), .busy(a_busy), .finish(a_finish)
   );

   conv_out_streamer #(.SIZE(3), .SIZEKer(3), .WIDTH_BIT(W)) u_b (
      .clock(clock), .nreset(nreset), .start(b_start),
      .rd_en(b_rd_en), .rd_row(b_rd_row), .rd_col(b_rd_col), .rd_data(b_rd_data),
      .m_valid(b_m_valid), .m_ready(b_m_ready), .m_data(b_m_data),
      .m_eol(b_m_eol), .m_eof(b_m_eof), .busy(b_busy), .finish(b_finish)
   );

   // Result buffers: one-cycle read latency, garbage when not read.
   always @(posedge clock) begin
      a_rd_data <= a_rd_en ? W'(int'(a_rd_row) * OUT_A + int'(a_rd_col)) : W'($urandom);
      b_rd_data <= b_rd_en ? -16'sd7 : W'($urandom);
   end

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   typedef struct packed {
      logic [W-1:0] d;
      logic         eol;
      logic         eof;
   } beat_t;

   beat_t got_q[$];
   int    n_rd, n_acc, n_fin, max_out, stab_err, addr_err;
   logic  prev_stall;
   beat_t prev_beat;

   // Stream monitor on instance a: collects accepted beats and counts protocol violations.
   always @(negedge clock) begin
      beat_t cur;
      cur.d   = a_m_data;
      cur.eol = a_m_eol;
      cur.eof = a_m_eof;
      if (a_rd_en === 1'b1) begin
         if (int'(a_rd_row) != n_rd / OUT_A || int'(a_rd_col) != n_rd % OUT_A) addr_err++;
         n_rd++;
      end
      if (prev_stall && (a_m_valid !== 1'b1 || cur !== prev_beat)) stab_err++;
      prev_stall = (a_m_valid === 1'b1) && !a_m_ready;
      prev_beat  = cur;
      if (a_m_valid === 1'b1 && a_m_ready) begin
         got_q.push_back(cur);
         n_acc++;
      end
      if (n_rd - n_acc > max_out) max_out = n_rd - n_acc;
      if (a_finish === 1'b1) n_fin++;
   end

   task automatic frame_clear();
      got_q.delete();
      n_rd = 0; n_acc = 0; n_fin = 0; max_out = 0; stab_err = 0; addr_err = 0;
      prev_stall = 1'b0;
   endtask

   // Reference: a frame is pixels 0..NPIX-1 in raster order, eol on last column, eof on last pixel.
   task automatic check_frame(input string tag);
      int bad;
      beat_t e;
      bad = 0;
      chk({tag, "_beats"}, got_q.size(), NPIX);
      for (int i = 0; i < NPIX && i < got_q.size(); i++) begin
         e.d   = W'(i);
         e.eol = (i % OUT_A) == OUT_A - 1;
         e.eof = (i == NPIX - 1);
         if (got_q[i] !== e) bad++;
      end
      chk({tag, "_beat_errs"}, bad, 0);
      chk({tag, "_reads"}, n_rd, NPIX);
      chk({tag, "_finish_cnt"}, n_fin, 1);
      chk({tag, "_over2_outstanding"}, max_out > 2, 0);
      chk({tag, "_stall_instab"}, stab_err, 0);
      chk({tag, "_addr_errs"}, addr_err, 0);
   endtask

   // mode: 0 ready=1, 1 toggle, 2 random, 3 stalled 20 cycles, 4 ready=1 with extra starts
   task automatic run_frame(input int mode, input bit chain, input string tag);
      int cyc;
      bit done;
      @(posedge clock); #1;
      frame_clear();
      cyc = 0;
      done = 0;
      while (!done && cyc < 600) begin
         case (mode)
            1:       a_m_ready = (cyc % 2 == 0);
            2:       a_m_ready = ($urandom_range(0, 2) != 0);
            3:       a_m_ready = (cyc >= 20);
            default: a_m_ready = 1'b1;
         endcase
         if (mode == 4) a_start = (cyc == 0 || cyc == 3 || cyc == 6 || cyc == 11);
         else           a_start = (cyc == 0);
         @(negedge clock); #1;
         if (mode == 3 && cyc == 19) begin
            chk({tag, "_stall_reads"}, n_rd, 2);
            chk({tag, "_stall_valid"}, a_m_valid, 1);
            chk({tag, "_stall_data"}, {a_m_data}, 0);
         end
         if (n_fin > 0) done = 1;
         else begin
            @(posedge clock); #1;
            cyc++;
         end
      end
      chk({tag, "_timeout"}, done, 1);
      if (!chain) begin
         @(posedge clock); #1;
         a_start = 1'b0;
         a_m_ready = 1'b1;
         repeat (3) @(negedge clock);
         #1;
         chk({tag, "_idle_busy"}, a_busy, 0);
      end
      check_frame(tag);
   endtask

   typedef struct {
      logic         start;
      logic         rd_en;
      logic [1:0]   row, col;
      logic         valid;
      logic [W-1:0] data;
      logic         eol, eof, busy, fin;
   } vec_t;

   vec_t tbl[13];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not end, failures=%0d", failures);
      $fatal(1);
   end

   initial begin
      int k;
      // Cycle-exact expectation for a frame with m_ready held high: reads on cycles 0..8, beats 2..10, finish on 11.
      for (int i = 0; i < 13; i++) begin
         tbl[i].start = (i == 0);
         tbl[i].rd_en = (i <= 8);
         tbl[i].row   = 2'(i / OUT_A);
         tbl[i].col   = 2'(i % OUT_A);
         tbl[i].valid = (i >= 2 && i <= 10);
         tbl[i].data  = W'(i - 2);
         tbl[i].eol   = (i >= 2) && ((i - 2) % OUT_A == OUT_A - 1);
         tbl[i].eof   = (i == 10);
         tbl[i].busy  = (i >= 1 && i <= 10);
         tbl[i].fin   = (i == 11);
      end

      nreset = 1'b0;
      a_start = 1'b0; a_m_ready = 1'b0;
      b_start = 1'b0; b_m_ready = 1'b0;
      frame_clear();
      #1;
      chk("rst_rd_en", a_rd_en, 0);
      chk("rst_m_valid", a_m_valid, 0);
      chk("rst_m_data", {a_m_data}, 0);
      chk("rst_eol_eof", {a_m_eol, a_m_eof}, 0);
      chk("rst_busy_fin", {a_busy, a_finish}, 0);
      chk("rst_addr", {a_rd_row, a_rd_col}, 0);
      chk("rst_b_outs", {b_rd_en, b_m_valid, b_m_data, b_busy, b_finish}, 0);
      #21 nreset = 1'b1;

      // Table-driven cycle-accurate frame.
      @(posedge clock); #1;
      frame_clear();
      for (int i = 0; i < 13; i++) begin
         a_start   = tbl[i].start;
         a_m_ready = 1'b1;
         @(negedge clock);
         chk($sformatf("tbl%0d_rd_en", i), a_rd_en, tbl[i].rd_en);
         if (tbl[i].rd_en) chk($sformatf("tbl%0d_addr", i), {a_rd_row, a_rd_col}, {tbl[i].row, tbl[i].col});
         chk($sformatf("tbl%0d_valid", i), a_m_valid, tbl[i].valid);
         if (tbl[i].valid) chk($sformatf("tbl%0d_beat", i), {a_m_data, a_m_eol, a_m_eof},
                               {tbl[i].data, tbl[i].eol, tbl[i].eof});
         chk($sformatf("tbl%0d_busy", i), a_busy, tbl[i].busy);
         chk($sformatf("tbl%0d_finish", i), a_finish, tbl[i].fin);
         @(posedge clock); #1;
      end
      #1;
      check_frame("tbl");

      run_frame(1, 0, "toggle");
      run_frame(3, 0, "stall20");
      run_frame(4, 0, "restart_ignored");

      // Reset mid-frame after beat 4 is accepted.
      @(posedge clock); #1;
      frame_clear();
      a_start = 1'b1;
      a_m_ready = 1'b1;
      k = 0;
      while (k < 50) begin
         @(negedge clock); #1;
         if (n_acc >= 5) break;
         @(posedge clock); #1;
         a_start = 1'b0;
         k++;
      end
      chk("midrst_reach_beat4", n_acc, 5);
      @(posedge clock); #1;
      nreset = 1'b0;
      #1;
      chk("midrst_rd_en", a_rd_en, 0);
      chk("midrst_m_valid", a_m_valid, 0);
      chk("midrst_m_data", {a_m_data}, 0);
      chk("midrst_eol_eof", {a_m_eol, a_m_eof}, 0);
      chk("midrst_busy_fin", {a_busy, a_finish}, 0);
      chk("midrst_no_finish", n_fin, 0);
      @(negedge clock); #1;
      nreset = 1'b1;
      frame_clear();
      repeat (2) @(negedge clock);
      #1;
      chk("midrst_stale_valid", a_m_valid, 0);
      chk("midrst_stale_beats", got_q.size(), 0);
      run_frame(0, 0, "after_reset");

      // Single-pixel output frame with a negative value.
      @(posedge clock); #1;
      b_start = 1'b1;
      b_m_ready = 1'b1;
      @(negedge clock);
      chk("one_c0_rd", {b_rd_en, b_rd_row, b_rd_col}, 3'b100);
      chk("one_c0_busy", b_busy, 0);
      @(posedge clock); #1;
      b_start = 1'b0;
      @(negedge clock);
      chk("one_c1_busy", b_busy, 1);
      chk("one_c1_rd_valid", {b_rd_en, b_m_valid}, 0);
      @(posedge clock); #1;
      @(negedge clock);
      chk("one_c2_valid", b_m_valid, 1);
      chk("one_c2_beat", {b_m_data, b_m_eol, b_m_eof}, {16'hFFF9, 2'b11});
      @(posedge clock); #1;
      @(negedge clock);
      chk("one_c3_fin", {b_finish, b_busy, b_m_valid}, 3'b100);
      @(posedge clock); #1;
      @(negedge clock);
      chk("one_c4_idle", {b_finish, b_busy, b_rd_en}, 0);

      // Random backpressure; chained frames restart in the IDLE cycle right after FIN.
      for (int f = 0; f < 6; f++)
         run_frame(2, (f < 5), $sformatf("rand%0d", f));
      run_frame(0, 0, "final");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/conv_out_streamer.md
CONV_OUT_STREAMER -- requirements
Module: conv_out_streamer

Interface
REQ-001 The block SHALL take parameter SIZE, default 256: input image edge length in pixels.
REQ-002 The block SHALL take parameter SIZEKer, default 3: kernel edge length.
REQ-003 The block SHALL take parameter WIDTH_BIT, default 16: signed pixel width.
REQ-004 Derived: OUT = SIZE-SIZEKer+1 (output edge); AW = max(1, ceil(log2(OUT))).
REQ-005 Port clock, input, 1: single clock, all state on rising edge.
REQ-006 Port nreset, input, 1: asynchronous active-low reset.
REQ-007 Port start, input, 1: one-cycle pulse from the convolution core's done; frame ready to read.
REQ-008 Port rd_en, output, 1: read strobe to the result buffer.
REQ-009 Port rd_row, output, AW: buffer row address.
REQ-010 Port rd_col, output, AW: buffer column address.
REQ-011 Port rd_data, input, WIDTH_BIT signed: buffer data, valid exactly 1 cycle after rd_en.
REQ-012 Port m_valid, output, 1: stream beat valid.
REQ-013 Port m_ready, input, 1: downstream accepts beat.
REQ-014 Port m_data, output, WIDTH_BIT signed: pixel value.
REQ-015 Port m_eol, output, 1: beat is last column of a row.
REQ-016 Port m_eof, output, 1: beat is last pixel of the frame (row OUT-1, col OUT-1).
REQ-017 Port busy, output, 1: frame transfer in progress.
REQ-018 Port finish, output, 1: one-cycle pulse after final beat accepted.

Function
REQ-019 FSM states SHALL be IDLE, RUN, DRAIN, FIN.
REQ-020 IDLE: start=1 -> RUN, read address cleared to (0,0), busy=1 from next cycle.
REQ-021 start SHALL be ignored in RUN, DRAIN and FIN.
REQ-022 Reads SHALL be issued raster order: col increments 0..OUT-1, then col wraps to 0 and row increments.
REQ-023 A 2-entry output FIFO SHALL hold returned data; rd_en SHALL assert only when (FIFO occupancy + reads in flight) < 2 counting a handshake in the same cycle as freeing one slot.
REQ-024 With m_ready held 1, after the first read the block SHALL sustain one beat per cycle; first m_valid SHALL rise 2 cycles after start (start -> rd_en -> rd_data -> m_valid registered).
REQ-025 A beat transfers when m_valid & m_ready; m_data/m_eol/m_eof SHALL be held stable while m_valid=1 and m_ready=0.
REQ-026 m_eol and m_eof SHALL travel with their data through the FIFO, derived from the address of the issuing read.
REQ-027 After issuing read (OUT-1,OUT-1): RUN -> DRAIN, no further rd_en.
REQ-028 DRAIN -> FIN on the handshake of the m_eof beat; FIN asserts finish for exactly one cycle, busy=0 in FIN, then -> IDLE.
REQ-029 Total accepted beats per frame SHALL be exactly OUT*OUT; no beat duplicated or dropped under any m_ready pattern.
REQ-030 rd_data SHALL be passed unmodified (no sign/width change).
REQ-031 OUT=1 SHALL work: single beat with m_eol=m_eof=1.
REQ-032 start in the FIN cycle SHALL be ignored; start in the following IDLE cycle SHALL begin a new frame.

Reset
REQ-033 nreset=0 SHALL immediately force: state IDLE, FIFO empty, in-flight cleared, addresses 0, rd_en=0, m_valid=0, m_data=0, m_eol=0, m_eof=0, busy=0, finish=0.
REQ-034 Reset mid-frame SHALL abandon the frame; no partial-frame finish; a returning rd_data after reset release SHALL be discarded.

Verification
REQ-035 SIZE=5, SIZEKer=3, buffer holds row*3+col, m_ready=1, start pulse -> 9 beats values 0..8 on consecutive cycles, m_eol on 2,5,8, m_eof on 8 only, finish one cycle after beat 8.
REQ-036 Same frame, m_ready toggling 1,0,1,0... -> same 9 values in order, data stable across stalls, never >2 reads outstanding+buffered.
REQ-037 Same frame, m_ready=0 for 20 cycles after start -> exactly 2 reads issued, m_valid=1 with value 0 held; release -> remaining 8 beats in order.
REQ-038 nreset low after beat 4 accepted -> all outputs 0 asynchronously; new start after release -> full 9-beat frame from value 0, one finish.
REQ-039 start repeated during RUN and in FIN cycle -> ignored, exactly 9 beats and one finish.
REQ-040 SIZE=3, SIZEKer=3, buffer value -7 (0xFFF9) -> single beat m_data=0xFFF9, m_eol=m_eof=1, finish next cycle.
